ram_io_responder: RTL

//  Memory-side responder for the byte-serial RAM bus that the memory controller drives (mem_a/mem_dout/mem_wr -> mem_din).

---
 rtl/ram_io_responder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ram_io_responder.sv
// Byte-serial RAM bus responder: byte RAM below IO_BASE, TX FIFO (and optional RX FIFO) in the IO window.
// Optional feature macro: IO_RX_EN (host-to-CPU RX FIFO behind IO_DATA reads).
module ram_io_responder #(
   parameter int unsigned ADDR_W      = 17,
   parameter logic [31:0] IO_BASE     = 32'h30000,
   parameter int unsigned TX_DEPTH    = 16,
   parameter int unsigned RX_DEPTH    = 16,
   parameter int unsigned FULL_MARGIN = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_overflow,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam int unsigned TXW     = $clog2(TX_DEPTH);
   localparam logic [TXW:0] TX_FULL = (TXW+1)'(TX_DEPTH);
   localparam logic [TXW:0] TX_HIGH = (TXW+1)'(TX_DEPTH - FULL_MARGIN);
   localparam logic [32:0] RAM_TOP = 33'd1 << ADDR_W;
   localparam logic [31:0] IO_STAT = IO_BASE + 32'd4;

   logic is_ram, is_io, is_stat, is_data;
   logic rx_nonempty, rd_hold;
   logic [7:0] rx_head;

   always_comb begin
      is_ram  = ({1'b0, mem_a} < RAM_TOP) && (mem_a < IO_BASE);
      is_io   = (mem_a >= IO_BASE);
      is_stat = (mem_a == IO_STAT);
      is_data = (mem_a == IO_BASE);
   end

   // ---------------- RAM and read path ----------------
   logic [7:0] ram [0:(2**ADDR_W)-1];
   logic [7:0] ram_rd_q;
   logic [7:0] io_rd_d, io_rd_q;
   logic       sel_ram_q;

   always_ff @(posedge clk) begin
      if (mem_wr && is_ram && !rst)
         ram[mem_a[ADDR_W-1:0]] <= mem_dout;
      if (!mem_wr)
         ram_rd_q <= ram[mem_a[ADDR_W-1:0]];
   end

   always_comb begin
      io_rd_d = '0;
      if (is_stat)
         io_rd_d = {6'b0, rx_nonempty, io_buffer_full};
      else if (is_data)
         io_rd_d = rx_head;
   end

   // RAM data stays in an unreset register; the select bit decides what mem_din shows
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_ram_q <= 1'b0;
         io_rd_q   <= '0;
      end else if (!mem_wr && !rd_hold) begin
         sel_ram_q <= is_ram;
         io_rd_q   <= io_rd_d;
      end
   end

   assign mem_din = sel_ram_q ? ram_rd_q : io_rd_q;

   // ---------------- TX FIFO ----------------
   logic [7:0]     tx_mem [TX_DEPTH];
   logic [TXW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [TXW:0]   tx_cnt_q, tx_cnt_d;
   logic           tx_ovf_q, tx_ovf_d, io_full_q;
   logic           tx_push_req, tx_push, tx_pop;

   always_comb begin
      tx_pop      = tx_valid && tx_ready;
      tx_push_req = mem_wr && is_io && !is_stat;
      tx_push     = tx_push_req && ((tx_cnt_q != TX_FULL) || tx_pop);
      tx_wr_d     = tx_wr_q;
      tx_rd_d     = tx_rd_q;
      tx_cnt_d    = tx_cnt_q;
      tx_ovf_d    = tx_ovf_q;
      if (tx_push)
         tx_wr_d = tx_wr_q + TXW'(1);
      if (tx_pop)
         tx_rd_d = tx_rd_q + TXW'(1);
      if (tx_push && !tx_pop)
         tx_cnt_d = tx_cnt_q + (TXW+1)'(1);
      else if (!tx_push && tx_pop)
         tx_cnt_d = tx_cnt_q - (TXW+1)'(1);
      if (tx_push_req && !tx_push)
         tx_ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wr_q   <= '0;
         tx_rd_q   <= '0;
         tx_cnt_q  <= '0;
         tx_ovf_q  <= 1'b0;
         io_full_q <= 1'b0;
      end else begin
         tx_wr_q   <= tx_wr_d;
         tx_rd_q   <= tx_rd_d;
         tx_cnt_q  <= tx_cnt_d;
         tx_ovf_q  <= tx_ovf_d;
         io_full_q <= (tx_cnt_d >= TX_HIGH);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push)
         tx_mem[tx_wr_q] <= mem_dout;
   end

   assign tx_valid       = (tx_cnt_q != '0);
   assign tx_data        = tx_valid ? tx_mem[tx_rd_q] : '0;
   assign tx_overflow    = tx_ovf_q;
   assign io_buffer_full = io_full_q;

   // ---------------- RX FIFO ----------------
`ifdef IO_RX_EN
   localparam int unsigned RXW     = $clog2(RX_DEPTH);
   localparam logic [RXW:0] RX_FULL = (RXW+1)'(RX_DEPTH);

   logic [7:0]     rx_mem [RX_DEPTH];
   logic [RXW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [RXW:0]   rx_cnt_q, rx_cnt_d;
   logic           rd_prev_q, cpu_rd_data, rx_push, rx_pop;

   // The controller holds a single-byte read for two cycles; only the first one pops.
   always_comb begin
      cpu_rd_data = !mem_wr && is_data;
      rx_push     = rx_valid && rx_ready;
      rx_pop      = cpu_rd_data && !rd_prev_q && rx_nonempty;
      rx_wr_d     = rx_push ? rx_wr_q + RXW'(1) : rx_wr_q;
      rx_rd_d     = rx_pop ? rx_rd_q + RXW'(1) : rx_rd_q;
      rx_cnt_d    = rx_cnt_q;
      if (rx_push && !rx_pop)
         rx_cnt_d = rx_cnt_q + (RXW+1)'(1);
      else if (!rx_push && rx_pop)
         rx_cnt_d = rx_cnt_q - (RXW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wr_q   <= '0;
         rx_rd_q   <= '0;
         rx_cnt_q  <= '0;
         rd_prev_q <= 1'b0;
      end else begin
         rx_wr_q   <= rx_wr_d;
         rx_rd_q   <= rx_rd_d;
         rx_cnt_q  <= rx_cnt_d;
         rd_prev_q <= cpu_rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_push)
         rx_mem[rx_wr_q] <= rx_data;
   end

   assign rx_ready    = !rst && (rx_cnt_q != RX_FULL);
   assign rx_nonempty = (rx_cnt_q != '0);
   assign rx_head     = rx_nonempty ? rx_mem[rx_rd_q] : '0;
   assign rd_hold     = cpu_rd_data && rd_prev_q;
`else
   logic unused_rx;
   assign unused_rx   = ^{rx_data, rx_valid, RX_DEPTH[0]};
   assign rx_ready    = 1'b0;
   assign rx_nonempty = 1'b0;
   assign rx_head     = '0;
   assign rd_hold     = 1'b0;
`endif

endmodule
